// File: rtl/stream_packet_source_pkg.sv
// Shared types for the stream packet source.
//   state_t : FSM state encoding (IDLE, SEND, GAP), also exported on state_dbg.
//   cmd_t   : packed command record (length, seed, gap) sized by the default
//             widths below, for users that move commands around as one word.
package stream_packet_source_pkg;

  localparam int DEFAULT_WIDTH_BITS  = 8;
  localparam int DEFAULT_LENGTH_BITS = 8;
  localparam int DEFAULT_GAP_BITS    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEFAULT_LENGTH_BITS-1:0] length;
    logic [DEFAULT_WIDTH_BITS-1:0]  seed;
    logic [DEFAULT_GAP_BITS-1:0]    gap;
  } cmd_t;

endpackage

// File: rtl/stream_packet_source_if.sv
// Valid/ready output stream carrying data beats with a last flag.
//   master : drives output_valid, output_data, output_last; samples output_ready
//   slave  : samples output_valid, output_data, output_last; drives output_ready
//
// Handshake: a beat transfers on a rising clock edge where output_valid and
// output_ready are both high. Once output_valid is raised, it and the
// data/last fields stay stable until that transfer; output_ready may change
// freely and must not depend combinationally on output_valid.
interface stream_packet_source_if
  import stream_packet_source_pkg::*;
#(
  parameter int WIDTH_BITS = DEFAULT_WIDTH_BITS
) ();

  logic                  output_valid;
  logic                  output_ready;
  logic [WIDTH_BITS-1:0] output_data;
  logic                  output_last;

  modport master (
    output output_valid,
    output output_data,
    output output_last,
    input  output_ready
  );

  modport slave (
    input  output_valid,
    input  output_data,
    input  output_last,
    output output_ready
  );

endinterface

// File: rtl/stream_packet_source.sv
// Packet traffic generator on a valid/ready stream.
// An accepted command (cmd_valid && cmd_ready) emits cmd_length beats of
// incrementing data starting at cmd_seed, inserting cmd_gap idle cycles after
// every non-final beat, with output_last on the final beat.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only while IDLE)
//   cmd_length        : beats in the packet (0 = no beats, just a done pulse)
//   cmd_seed          : data of the first beat
//   cmd_gap           : idle cycles after each non-final beat
//   stream            : output stream (master modport)
//   busy              : high while a packet is in flight (SEND or GAP)
//   done              : one-cycle pulse after a packet completes
//   state_dbg         : current FSM state
module stream_packet_source
  import stream_packet_source_pkg::*;
#(
  parameter int WIDTH_BITS  = DEFAULT_WIDTH_BITS,
  parameter int LENGTH_BITS = DEFAULT_LENGTH_BITS,
  parameter int GAP_BITS    = DEFAULT_GAP_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LENGTH_BITS-1:0] cmd_length,
  input  logic [WIDTH_BITS-1:0]  cmd_seed,
  input  logic [GAP_BITS-1:0]    cmd_gap,
  stream_packet_source_if.master stream,
  output logic                   busy,
  output logic                   done,
  output state_t                 state_dbg
);

  localparam logic [WIDTH_BITS-1:0]  DATA_ONE = WIDTH_BITS'(1);
  localparam logic [LENGTH_BITS-1:0] LEN_ONE  = LENGTH_BITS'(1);
  localparam logic [LENGTH_BITS-1:0] LEN_TWO  = LENGTH_BITS'(2);
  localparam logic [GAP_BITS-1:0]    GAP_ONE  = GAP_BITS'(1);

  state_t                 state;
  logic [WIDTH_BITS-1:0]  data_q;     // current / next beat value
  logic [LENGTH_BITS-1:0] remaining;  // beats still to transfer, incl. current
  logic [GAP_BITS-1:0]    gap_len;    // captured idle length
  logic [GAP_BITS-1:0]    gap_cnt;    // idle cycles left in GAP
  logic                   valid_q;
  logic                   last_q;
  logic                   done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      data_q    <= '0;
      remaining <= '0;
      gap_len   <= '0;
      gap_cnt   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // cmd_ready is high throughout IDLE, so cmd_valid alone accepts.
          if (cmd_valid) begin
            data_q    <= cmd_seed;
            remaining <= cmd_length;
            gap_len   <= cmd_gap;
            if (cmd_length == '0) begin
              done_q <= 1'b1;
            end else begin
              state   <= SEND;
              valid_q <= 1'b1;
              last_q  <= (cmd_length == LEN_ONE);
            end
          end
        end
        SEND: begin
          if (stream.output_ready) begin
            if (last_q) begin
              state     <= IDLE;
              valid_q   <= 1'b0;
              last_q    <= 1'b0;
              done_q    <= 1'b1;
              remaining <= '0;
            end else begin
              // Advance to the next beat now so GAP holds the next-beat value.
              data_q    <= data_q + DATA_ONE;
              remaining <= remaining - LEN_ONE;
              if (gap_len == '0) begin
                last_q <= (remaining == LEN_TWO);
              end else begin
                state   <= GAP;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                gap_cnt <= gap_len;
              end
            end
          end
        end
        GAP: begin
          // remaining was already decremented on the handshake that got us here.
          gap_cnt <= gap_cnt - GAP_ONE;
          if (gap_cnt == GAP_ONE) begin
            state   <= SEND;
            valid_q <= 1'b1;
            last_q  <= (remaining == LEN_ONE);
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stream.output_valid = valid_q;
  assign stream.output_data  = data_q;
  assign stream.output_last  = last_q;
  assign cmd_ready           = (state == IDLE);
  assign busy                = (state != IDLE);
  assign done                = done_q;
  assign state_dbg           = state;

endmodule

// File: tb/tb_stream_packet_source.sv
// Bench for stream_packet_source: directed scenarios plus random commands,
// with a queue of expected beats {gap_before, last, data} filled at command
// acceptance and drained by an independent negedge monitor.
module tb_stream_packet_source;
  import stream_packet_source_pkg::*;

  localparam int W  = 8;
  localparam int LB = 8;
  localparam int GB = 4;
  localparam int EW = GB + 1 + W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LB-1:0] cmd_length = '0;
  logic [W-1:0]  cmd_seed = '0;
  logic [GB-1:0] cmd_gap = '0;
  logic          busy;
  logic          done;
  state_t        state_dbg;

  stream_packet_source_if #(.WIDTH_BITS(W)) stream ();

  stream_packet_source #(
    .WIDTH_BITS(W),
    .LENGTH_BITS(LB),
    .GAP_BITS(GB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_length(cmd_length),
    .cmd_seed(cmd_seed),
    .cmd_gap(cmd_gap),
    .stream(stream),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            pkt_active = 0;
  bit            done_exp = 0;
  bit            accept_flag = 0;
  bit            rand_ready = 0;
  int            hs_count = 0;
  int            idle = 0;
  bit            prev_stall = 0;
  logic [W-1:0]  prev_data;
  logic          prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: beat i of a packet carries (seed + i) mod 2^W, the last
  // beat is index len-1, and every beat after the first follows gap idle cycles.
  task automatic model_push(input int len, input int sd, input int gp);
    for (int i = 0; i < len; i++) begin
      logic [W-1:0]  d;
      logic [GB-1:0] g;
      logic          l;
      d = W'((sd + i) % (1 << W));
      g = (i == 0) ? GB'(0) : GB'(gp);
      l = (i == len - 1);
      exp_q.push_back({g, l, d});
    end
  endtask

  // ---------------- driver tasks ----------------
  initial begin
    stream.output_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      stream.output_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input int len, input int sd, input int gp, input bit keep_valid,
                          output logic done_at_accept);
    bit   acc;
    logic rdy;
    logic d;
    acc = 0;
    done_at_accept = 1'b0;
    cmd_length = LB'(len);
    cmd_seed   = W'(sd);
    cmd_gap    = GB'(gp);
    cmd_valid  = 1'b1;
    for (int k = 0; k < 600 && !acc; k++) begin
      @(negedge clock);
      rdy = cmd_ready;
      d   = done;
      @(posedge clock);
      if (rdy) begin
        acc = 1;
        done_at_accept = d;
        model_push(len, sd, gp);
        accept_flag = 1;
        if (len > 0) pkt_active = 1;
        else done_exp = 1;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got no accept expected accept of len %0d", len);
    end
    #1;
    if (!keep_valid) begin
      cmd_valid  = 1'b0;
      cmd_length = LB'($urandom);
      cmd_seed   = W'($urandom);
      cmd_gap    = GB'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(posedge clock);
      if (exp_q.size() == 0 && !pkt_active) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      idle       = 0;
      prev_stall = 0;
    end else begin
      if (accept_flag) begin
        idle        = 0;
        accept_flag = 0;
      end
      chk("busy", busy, pkt_active);
      chk("cmd_ready", cmd_ready, !pkt_active);
      chk("done", done, done_exp);
      done_exp = 0;
      if (!stream.output_valid) chk("last_without_valid", stream.output_last, 0);
      if (prev_stall) begin
        chk("hold_valid", stream.output_valid, 1);
        chk("hold_data", stream.output_data, prev_data);
        chk("hold_last", stream.output_last, prev_last);
      end
      if (stream.output_valid && stream.output_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h expected no beat", stream.output_data);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("beat_data", stream.output_data, e[W-1:0]);
          chk("beat_last", stream.output_last, e[W]);
          chk("gap_idle", idle, e[EW-1:W+1]);
          if (e[W]) begin
            pkt_active = 0;
            done_exp   = 1;
          end
        end
        hs_count++;
        idle = 0;
      end else if (!stream.output_valid) begin
        idle++;
      end
      prev_stall = stream.output_valid && !stream.output_ready;
      prev_data  = stream.output_data;
      prev_last  = stream.output_last;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic d;
    int   base;
    bit   hit;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_valid", stream.output_valid, 0);
    chk("reset_data", stream.output_data, 0);
    chk("reset_last", stream.output_last, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", state_dbg, IDLE);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    @(posedge clock);
    #1;

    // Full-throughput packet.
    send_cmd(4, 'h10, 0, 0, d);
    wait_idle();

    // Gapped packet wrapping through 0xFF.
    send_cmd(3, 'hFE, 2, 0, d);
    wait_idle();

    // Random backpressure.
    rand_ready = 1;
    send_cmd(5, 'h00, 0, 0, d);
    wait_idle();
    rand_ready = 0;

    // Zero-length command: done only.
    send_cmd(0, 'h33, 1, 0, d);
    wait_idle();

    // Reset after the 3rd handshake of an 8-beat packet.
    base = hs_count;
    send_cmd(8, 'h80, 0, 0, d);
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(posedge clock);
      if (hs_count >= base + 3) hit = 1;
    end
    chk("reset_test_reached_3_beats", hs_count - base, 3);
    #1;
    reset = 1'b1;
    @(posedge clock);
    exp_q.delete();
    pkt_active = 0;
    done_exp   = 0;
    @(negedge clock);
    chk("abort_valid", stream.output_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    send_cmd(2, 'h40, 0, 0, d);
    wait_idle();

    // Back-to-back commands with cmd_valid held high.
    send_cmd(2, 'h20, 1, 1, d);
    send_cmd(1, 'h90, 3, 0, d);
    chk("b2b_accept_in_done_cycle", d, 1);
    wait_idle();

    // Random commands under random backpressure.
    for (int n = 0; n < 20; n++) begin
      rand_ready = ($urandom_range(0, 1) == 1);
      send_cmd($urandom_range(0, 10), $urandom_range(0, 255), $urandom_range(0, 3), 0, d);
    end
    wait_idle();
    rand_ready = 0;

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_packet_source.md
Name: stream_packet_source

Overview:
Valid/ready stream transmitter. It is the producing end of the team's valid/ready stream interface and feeds register slices, FIFOs and sinks.
- On an accepted command it emits a packet of incrementing data beats, with a last flag on the final beat.
- Optional idle gaps between beats exercise downstream throttling.
- Used as the traffic generator in the valid/ready chapter demos and benches.

Parameters:
WIDTH_BITS, 8, output data width
LENGTH_BITS, 8, width of beat-count field (max packet 2^LENGTH_BITS-1 beats)
GAP_BITS, 4, width of inter-beat idle-cycle field

Ports:
clock  input  1  clock
reset  input  1  synchronous reset, active-high
cmd_valid  input  1  command VALID
cmd_ready  output  1  command READY, high only in IDLE
cmd_length  input  LENGTH_BITS  number of beats in packet (0 allowed)
cmd_seed  input  WIDTH_BITS  data value of first beat
cmd_gap  input  GAP_BITS  idle cycles inserted after each non-final beat
output_valid  output  1  stream VALID
output_ready  input  1  stream READY
output_data  output  WIDTH_BITS  stream data
output_last  output  1  high on final beat of packet
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when a packet completes

Behaviour:
- Reset (synchronous, active-high, clock = clock): state=IDLE; output_valid=0, output_data=0, output_last=0, done=0, busy=0; cmd_ready=1 from the cycle after reset deasserts. Reset mid-packet aborts immediately with no done pulse and no further beats.
- States: IDLE, SEND, GAP. The state encoding is a typedef enum.
- cmd_ready = (state==IDLE). The command is accepted on an edge where cmd_valid && cmd_ready.
  - All cmd_* fields are captured into internal registers at acceptance.
  - Later changes to cmd_* inputs have no effect on the packet in progress.
- Accept with cmd_length>0 -> SEND. output_valid=1 from the next cycle, output_data=cmd_seed, output_last=(cmd_length==1).
- Accept with cmd_length==0 -> stay IDLE. No beats are emitted; done=1 for exactly the next cycle.
- SEND: output_valid=1. While output_ready=0, output_data and output_last hold stable; valid never drops without a handshake.
- Handshake (output_valid && output_ready) on a non-final beat:
  - Data increments by 1, modulo 2^WIDTH_BITS (wraps 0xFF->0x00 for WIDTH_BITS=8).
  - Remaining count decrements.
  - If gap==0: stay in SEND and present the next beat the next cycle (full throughput, one beat per clock).
  - If gap>0: go to GAP with output_valid=0 for exactly gap cycles, then SEND with the next beat.
- Handshake on the final beat (output_last=1): go to IDLE. Next cycle: output_valid=0, output_last=0, done=1 (one cycle), cmd_ready=1.
- A new command may be accepted in the same cycle done is high.
- output_last is asserted only while output_valid=1.
- GAP: output_ready is ignored and output_data is held at the next-beat value.
- Beat count: exactly cmd_length handshakes per packet. Beat i carries data (seed+i) mod 2^WIDTH_BITS.
- busy=1 in SEND and GAP.
- Latency: accept edge T -> first beat valid at T+1 -> final handshake at edge E -> done at E+1.

Decomposition:
- Package stream_packet_source_pkg holds:
  - state enum typedef (IDLE, SEND, GAP);
  - a packed command struct typedef (length, seed, gap), parameterised via localparams mirrored from module defaults.
- No sub-module. Remaining-beat and gap counters stay inline. The module is a single FSM plus counters, about 150 lines.

Test Plan:
- cmd length=4 seed=0x10 gap=0, output_ready=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles; last only on 0x13; done one cycle after 0x13 handshake.
- length=3 seed=0xFE gap=2, ready=1 -> data 0xFE,0xFF,0x00; exactly 2 valid-low cycles between beats; last on 0x00.
- length=5 seed=0 gap=0, output_ready toggling pseudo-random -> data/last stable while valid&&!ready; exactly 5 handshakes, sequence 0..4; no valid drop before handshake.
- length=0 -> no output_valid; done pulse the cycle after accept; cmd_ready stays 1.
- length=8, reset asserted after 3rd handshake -> next cycle output_valid=0, busy=0, no done; subsequent cmd length=2 seed=0x40 produces 0x40,0x41.
- cmd_valid held high with back-to-back commands (len 2 then len 1) -> second command accepted the cycle done=1; cmd_ready=0 throughout the first packet; cmd_* changes during the first packet have no effect.
